// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, FSM states and
// the sub-encoding used by the optional iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_XOR   = 4'd2,
        OP_OR    = 4'd3,
        OP_AND   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Matches op[1:0] of ops 10-13 so the top can pass the low bits straight through.
    typedef enum logic [1:0] {
        MD_DIVU  = 2'd0,
        MD_REMU  = 2'd1,
        MD_MUL   = 2'd2,
        MD_MULHU = 2'd3
    } md_op_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op_e'(op) inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU});
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative unit: shift-add multiplier and restoring divider sharing
// one hi/lo register pair; one step per cycle for exactly WIDTH cycles.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    md_op_e           op_q, op_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, dvs_q});
        div_sub = div_sh[WIDTH-1:0] - dvs_q;

        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dvs_d = dvs_q;
        op_d  = op_q;
        if (start_i) begin
            cnt_d = CNT_W'(WIDTH);
            hi_d  = '0;
            op_d  = md_op_e'(op_i);
            // Divide: lo holds the dividend and fills with quotient bits; multiply: lo holds the multiplier.
            if (op_i[1]) begin
                lo_d  = b_i;
                dvs_d = a_i;
            end else begin
                lo_d  = a_i;
                dvs_d = b_i;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == MD_MUL || op_q == MD_MULHU) begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else begin
                hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end
        end
    end

    assign last_o   = (cnt_q == CNT_W'(1));
    assign result_o = op_q[0] ? hi_d : lo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dvs_q <= '0;
            op_q  <= MD_DIVU;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dvs_q <= dvs_d;
            op_q  <= op_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake. Ops 10-13 use the iterative unit
// only when ALU_SEQ_MULDIV_EN is defined; otherwise they complete in one cycle with 0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             accept;
    logic             is_iter;
    logic             iter_last;
    logic [WIDTH-1:0] iter_result;

    function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0] f_op,
                                                     input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic [SH_W-1:0] sh;
        sh = y[SH_W-1:0];
        case (op_e'(f_op))
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_XOR:  return x ^ y;
            OP_OR:   return x | y;
            OP_AND:  return x & y;
            OP_SLL:  return x << sh;
            OP_SRL:  return x >> sh;
            OP_SRA:  return $unsigned($signed(x) >>> sh);
            OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (x < y)};
            default: return '0;
        endcase
    endfunction

`ifdef ALU_SEQ_MULDIV_EN
    assign is_iter = is_muldiv(op);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept && is_iter),
        .op_i     (op[1:0]),
        .a_i      (a),
        .b_i      (b),
        .last_o   (iter_last),
        .result_o (iter_result)
    );
`else
    assign is_iter     = 1'b0;
    assign iter_last   = 1'b0;
    assign iter_result = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_last) state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) state_d = is_iter ? ST_BUSY : ST_DONE;
                    else          state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_BUSY);
        accept    = in_valid && in_ready;
    end

    // Operands are sampled only on the accepting edge; result holds otherwise.
    always_comb begin
        result_d = result_q;
        if (accept && !is_iter) begin
            result_d = alu_simple(op, a, b);
        end else if ((state_q == ST_BUSY) && iter_last) begin
            result_d = iter_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; iterative-op expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int nvec = 0;
    int nerr = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        a  = $urandom;
        b  = $urandom;
        op = 4'($urandom_range(0, 15));
    endtask

    // Issue one request (accepted immediately: IDLE, or DONE with out_ready high) and check it.
    task automatic simple(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp, input string tag);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        check(tag, {out_valid, busy, result}, {1'b1, 1'b0, exp});
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic iter(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp, input string tag);
        int lat;
        int nb;
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        lat = 1;
        nb  = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nb++;
            tick();
            lat++;
        end
        check(tag, {out_valid, busy, result}, {1'b1, 1'b0, exp});
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_busy"}, 64'(nb), 64'd32);
    endtask
`endif

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        repeat (3) tick();
        check("rst_state", {out_valid, busy, result}, {1'b0, 1'b0, 32'h0});
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Back-to-back single-cycle ops
        simple(4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, "add_wrap");
        simple(4'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, "sub_wrap");
        simple(4'd2, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115, "xor");
        simple(4'd3, 32'h00FF_0000, 32'h0000_F00F, 32'h00FF_F00F, "or");
        simple(4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, "and");
        simple(4'd5, 32'h1,         32'h24,        32'h10,        "sll_mask");
        simple(4'd5, 32'h8000_0001, 32'd31,        32'h8000_0000, "sll_31");
        simple(4'd6, 32'h8000_0000, 32'h24,        32'h0800_0000, "srl");
        simple(4'd7, 32'h8000_0000, 32'h24,        32'hF800_0000, "sra_neg");
        simple(4'd7, 32'h4000_0000, 32'd4,         32'h0400_0000, "sra_pos");
        simple(4'd8, 32'hFFFF_FFFF, 32'd1,         32'h1,         "slt_neg");
        simple(4'd9, 32'hFFFF_FFFF, 32'd1,         32'h0,         "sltu_big");
        simple(4'd8, 32'd5,         32'd3,         32'h0,         "slt_gt");
        simple(4'd9, 32'd1,         32'hFFFF_FFFF, 32'h1,         "sltu_lt");
        simple(4'd14, 32'd123,      32'd456,       32'h0,         "op14");
        simple(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        "op15");
        tick();
        check("idle_after", {out_valid, busy, in_ready}, 3'b001);

`ifdef ALU_SEQ_MULDIV_EN
        iter(4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul");
        iter(4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "mulhu");
        iter(4'd12, 32'd100,       32'd0,         32'hFFFF_FFFF, "divu_zero");
        iter(4'd13, 32'd100,       32'd0,         32'd100,       "remu_zero");
        iter(4'd12, 32'd100,       32'd7,         32'd14,        "divu");
        iter(4'd13, 32'd100,       32'd7,         32'd2,         "remu");
        iter(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        iter(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max");
        iter(4'd12, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, "divu_big");
        iter(4'd13, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, "remu_zero_big");
`else
        simple(4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0, "mul_off");
        simple(4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0, "mulhu_off");
        simple(4'd12, 32'd100,       32'd7,         32'h0, "divu_off");
        simple(4'd13, 32'd100,       32'd0,         32'h0, "remu_off");
`endif
        tick();
        check("idle_after_md", {out_valid, busy, in_ready}, 3'b001);

        // Stall in DONE: result held, in_ready low, competing request ignored
        out_ready = 1'b0;
        simple(4'd0, 32'd1, 32'd2, 32'd3, "stall_issue");
        op = 4'd1; a = 32'd9; b = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd3});
        end
        op = 4'd1; a = 32'd5; b = 32'd7; out_ready = 1'b1;
        #1;
        check("handoff_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        scramble();
        check("handoff_next", {out_valid, result}, {1'b1, 32'hFFFF_FFFE});
        tick();
        check("handoff_idle", {out_valid, in_ready}, 2'b01);

        // Reset while a result is pending in DONE
        out_ready = 1'b0;
        simple(4'd0, 32'd1, 32'd1, 32'd2, "rst_done_issue");
        rst = 1'b1;
        #1;
        check("rst_done_clear", {out_valid, busy, result}, {1'b0, 1'b0, 32'h0});
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (3) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_done_novalid", 64'(seen), 64'd0);
        check("rst_done_ready", in_ready, 1'b1);

`ifdef ALU_SEQ_MULDIV_EN
        // Reset in the middle of an iterative divide
        op = 4'd12; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        repeat (10) tick();
        check("rst_busy_pre", {busy, out_valid}, 2'b10);
        rst = 1'b1;
        #1;
        check("rst_busy_clear", {busy, out_valid}, 2'b00);
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid || busy) seen++;
        end
        check("rst_busy_novalid", 64'(seen), 64'd0);
        check("rst_busy_ready", in_ready, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; power of two, 8..64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port in_valid  input  1  operation request valid.
REQ-005 SHALL provide port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL provide ports a, b  input  WIDTH  operands; op  input  4  operation code.
REQ-007 SHALL provide port out_valid  output  1  result valid.
REQ-008 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-009 SHALL provide port result  output  WIDTH  registered result; busy  output  1  iterative operation in progress.

Function
REQ-010 SHALL decode op: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT signed, 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14-15 result 0.
REQ-011 SHALL use only b[$clog2(WIDTH)-1:0] as shift amount; SRA SHALL replicate a[WIDTH-1].
REQ-012 SHALL zero-extend SLT/SLTU compare bit to WIDTH; ADD/SUB/MUL wrap modulo 2^WIDTH.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; a request is accepted when in_valid && in_ready.
REQ-014 SHALL assert in_ready in IDLE, and in DONE when out_ready is high (back-to-back issue); deassert in BUSY.
REQ-015 SHALL, for ops 0-9 and 14-15, capture result and go to DONE on the accepting edge (latency 1 cycle, throughput 1/cycle).
REQ-016 SHALL, for ops 10-13, go to BUSY on acceptance, iterate radix-2 for exactly WIDTH cycles, then DONE (latency WIDTH+1 cycles).
REQ-017 SHALL hold result and out_valid stable in DONE until out_ready; on out_ready without new request return to IDLE.
REQ-018 SHALL, on simultaneous result handoff and new acceptance in DONE, consume old result and start new operation in the same edge.
REQ-019 SHALL, for DIVU by zero, return all ones; REMU by zero returns a.
REQ-020 SHALL register operands only on acceptance; a, b, op SHALL be ignored at all other times (operand isolation for power).
REQ-021 SHALL assert busy exactly while in BUSY; iteration counter width $clog2(WIDTH)+1.

Reset
REQ-022 SHALL on rst force state IDLE, result 0, out_valid 0, busy 0, counter 0, operand registers 0; in_ready 1 after release.
REQ-023 SHALL, on rst during BUSY or DONE, abort the operation and discard the pending result without producing out_valid.

Configuration
REQ-024 SHALL, with ALU_SEQ_MULDIV_EN defined, implement ops 10-13 per REQ-016/REQ-019.
REQ-025 SHALL, without ALU_SEQ_MULDIV_EN, treat ops 10-13 as single-cycle returning 0, never enter BUSY, and synthesise no iterative datapath.

Structure
REQ-026 SHALL place op encodings (localparams/enum) and FSM state encoding in shared package alu_pkg.
REQ-027 SHALL implement the iterative shift-add multiplier / restoring divider as sub-module alu_muldiv_iter, instantiated only under ALU_SEQ_MULDIV_EN.

Verification
REQ-028 SHALL cover: reset, then op 0 a=0xFFFFFFFF b=1 -> out_valid next cycle, result 0x00000000.
REQ-029 SHALL cover: op 7 a=0x80000000 b=0x00000024 -> result 0xF8000000 (shift amount 4).
REQ-030 SHALL cover: op 10 a=0x00010000 b=0x00010000 then op 11 same operands -> results 0x00000000 and 0x00000001, each after 33 cycles, busy high 32 cycles.
REQ-031 SHALL cover: op 12 a=100 b=0 -> 0xFFFFFFFF; op 13 a=100 b=0 -> 100; op 12 a=100 b=7 -> 14.
REQ-032 SHALL cover: out_ready low 5 cycles in DONE -> result stable, in_ready low; then out_ready high with in_valid high op 1 a=5 b=7 -> next result 0xFFFFFFFE one cycle later.
REQ-033 SHALL cover: rst asserted mid-BUSY of op 12 -> out_valid never asserted for it, in_ready 1 after release.
